// File: rtl/simon_serial_host_if.sv
// Signal bundle between the plaintext/ciphertext front end, simon_serial_host and the serial
// SIMON core. The host uses the slave modport; the front end / core model uses master.
interface simon_serial_host_if #(
  parameter int unsigned BLOCK_BITS = 128
);
  logic [BLOCK_BITS-1:0] pt_in;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [BLOCK_BITS-1:0] ct_out;
  logic                  ct_valid;
  logic                  ct_ready;
  logic                  core_data_in;
  logic [1:0]            core_data_rdy;
  logic                  core_cipher_out;
  logic                  core_valid;
  logic                  busy;
  logic                  err;

  modport slave (
    input  pt_in, pt_valid, ct_ready, core_cipher_out, core_valid,
    output pt_ready, ct_out, ct_valid, core_data_in, core_data_rdy, busy, err
  );

  modport master (
    output pt_in, pt_valid, ct_ready, core_cipher_out, core_valid,
    input  pt_ready, ct_out, ct_valid, core_data_in, core_data_rdy, busy, err
  );
endinterface

// File: rtl/simon_serial_host.sv
// Host sequencer for the bit-serial SIMON core: loads key/plaintext serially, captures ciphertext.
// Optional RUN watchdog enabled by defining SIMON_HOST_TIMEOUT_EN.
module simon_serial_host #(
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned KEY_BITS   = 128
`ifdef SIMON_HOST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT    = 4095
`endif
) (
  input  logic               clk,
  input  logic               reset,
  simon_serial_host_if.slave bus
);

  localparam int unsigned MaxBits = (KEY_BITS > BLOCK_BITS) ? KEY_BITS : BLOCK_BITS;
  localparam int unsigned CntW    = $clog2(MaxBits) + 1;
  localparam logic [CntW-1:0] KeyLast = CntW'(KEY_BITS - 1);
  localparam logic [CntW-1:0] PtLast  = CntW'(BLOCK_BITS - 1);
  // Bit 0 is captured on the RUN exit edge, so CAPTURE counts the remaining BLOCK_BITS-1.
  localparam logic [CntW-1:0] CapLast = CntW'(BLOCK_BITS - 2);

  typedef enum logic [2:0] {StIdle, StLoadKey, StLoadPt, StRun, StCapture, StHold} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [BLOCK_BITS-1:0] pt_sr_q;
  logic [BLOCK_BITS-1:0] ct_sr_q;
  logic                  pt_ready_q;
  logic                  ct_valid_q;
  logic                  data_in_q;
  logic [1:0]            data_rdy_q;
  logic                  busy_q;

`ifdef SIMON_HOST_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  logic [WdW-1:0] wd_q;
  logic           err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pt_sr_q    <= '0;
      ct_sr_q    <= '0;
      pt_ready_q <= 1'b1;
      ct_valid_q <= 1'b0;
      data_in_q  <= 1'b0;
      data_rdy_q <= 2'b00;
      busy_q     <= 1'b0;
`ifdef SIMON_HOST_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.pt_valid && pt_ready_q) begin
            pt_sr_q    <= bus.pt_in;
            pt_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            data_rdy_q <= 2'b01;
            data_in_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StLoadKey;
          end
        end
        StLoadKey: begin
          if (cnt_q == KeyLast) begin
            // Present plaintext bit 0 in the first LOAD_PT cycle.
            cnt_q      <= '0;
            data_rdy_q <= 2'b10;
            data_in_q  <= pt_sr_q[0];
            pt_sr_q    <= pt_sr_q >> 1;
            state_q    <= StLoadPt;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StLoadPt: begin
          if (cnt_q == PtLast) begin
            cnt_q      <= '0;
            data_rdy_q <= 2'b11;
            data_in_q  <= 1'b0;
            state_q    <= StRun;
`ifdef SIMON_HOST_TIMEOUT_EN
            wd_q       <= '0;
`endif
          end else begin
            cnt_q     <= cnt_q + CntW'(1);
            data_in_q <= pt_sr_q[0];
            pt_sr_q   <= pt_sr_q >> 1;
          end
        end
        StRun: begin
          if (bus.core_valid) begin
            ct_sr_q <= {bus.core_cipher_out, ct_sr_q[BLOCK_BITS-1:1]};
            cnt_q   <= '0;
            state_q <= StCapture;
`ifdef SIMON_HOST_TIMEOUT_EN
            wd_q    <= '0;
          end else if (wd_q == WdLast) begin
            wd_q       <= '0;
            err_q      <= 1'b1;
            data_rdy_q <= 2'b00;
            pt_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            wd_q <= wd_q + WdW'(1);
`endif
          end
        end
        StCapture: begin
          if (bus.core_valid) begin
            ct_sr_q <= {bus.core_cipher_out, ct_sr_q[BLOCK_BITS-1:1]};
            if (cnt_q == CapLast) begin
              cnt_q      <= '0;
              ct_valid_q <= 1'b1;
              data_rdy_q <= 2'b00;
              state_q    <= StHold;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StHold: begin
          if (bus.ct_ready) begin
            ct_valid_q <= 1'b0;
            pt_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pt_ready      = pt_ready_q;
  assign bus.ct_valid      = ct_valid_q;
  assign bus.ct_out        = ct_sr_q;
  assign bus.core_data_in  = data_in_q;
  assign bus.core_data_rdy = data_rdy_q;
  assign bus.busy          = busy_q;
`ifdef SIMON_HOST_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_simon_serial_host.sv
// Directed self-checking bench for simon_serial_host; the timeout scenario runs when
// SIMON_HOST_TIMEOUT_EN is defined (TIMEOUT=16), otherwise RUN must wait without error.
module tb_simon_serial_host;
  localparam int unsigned BlockBits = 128;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [127:0] pt;
  logic [127:0] got;
  logic [127:0] ct_snap;
  logic [7:0]   a5;
  int           ok;
  int           b;
  int           c;

  simon_serial_host_if #(.BLOCK_BITS(BlockBits)) bus ();

  simon_serial_host #(
    .BLOCK_BITS(BlockBits),
    .KEY_BITS  (128)
`ifdef SIMON_HOST_TIMEOUT_EN
    ,
    .TIMEOUT   (16)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the first LOAD_KEY cycle.
  task automatic send_pt(input logic [127:0] p);
    bus.pt_in    = p;
    bus.pt_valid = 1'b1;
    @(negedge clk);
    bus.pt_valid = 1'b0;
  endtask

  initial begin
    bus.pt_in           = '0;
    bus.pt_valid        = 1'b0;
    bus.ct_ready        = 1'b0;
    bus.core_valid      = 1'b0;
    bus.core_cipher_out = 1'b0;
    a5 = 8'hA5;

    // 1: reset then idle
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_pt_ready", bus.pt_ready, 1'b1);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_data_rdy", bus.core_data_rdy, 2'b00);
    check_eq("rst_ct_valid", bus.ct_valid, 1'b0);
    check_eq("rst_err", bus.err, 1'b0);
    check_eq("rst_ct_out", bus.ct_out, 128'h0);

    // 2: load sequence; core_valid is driven high during loads and must be ignored
    pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
    bus.core_valid      = 1'b1;
    bus.core_cipher_out = 1'b1;
    send_pt(pt);
    ok = 0;
    for (int i = 0; i < 128; i++) begin
      if (bus.core_data_rdy == 2'b01 && bus.core_data_in == 1'b0 && bus.busy && !bus.pt_ready)
        ok++;
      @(negedge clk);
    end
    check_eq("key_load_cycles", ok, 128);
    ok  = 0;
    got = '0;
    for (int i = 0; i < 128; i++) begin
      if (bus.core_data_rdy == 2'b10) ok++;
      got[i] = bus.core_data_in;
      @(negedge clk);
    end
    check_eq("pt_load_cycles", ok, 128);
    check_eq("pt_first_bits", got[7:0], 8'h10);
    check_eq("pt_serial", got, pt);
    check_eq("run_rdy", bus.core_data_rdy, 2'b11);
    check_eq("run_data_in", bus.core_data_in, 1'b0);
    check_eq("run_ct_valid", bus.ct_valid, 1'b0);

    // 3: capture, every 3rd cycle stalled with an inverted (ignored) bit
    b = 0;
    c = 0;
    ok = 0;
    while (b < 128 && c < 400) begin
      if (c % 3 == 2) begin
        bus.core_valid      = 1'b0;
        bus.core_cipher_out = ~a5[b % 8];
      end else begin
        bus.core_valid      = 1'b1;
        bus.core_cipher_out = a5[b % 8];
        b++;
      end
      c++;
      if (!bus.ct_valid && bus.core_data_rdy == 2'b11) ok++;
      @(negedge clk);
    end
    bus.core_valid = 1'b0;
    check_eq("capture_cycles", ok, c);
    check_eq("cap_ct_valid", bus.ct_valid, 1'b1);
    check_eq("cap_ct_out", bus.ct_out, {16{8'hA5}});
    check_eq("hold_rdy", bus.core_data_rdy, 2'b00);

    // 4: backpressure in HOLD with a competing pt offer
    ct_snap      = {16{8'hA5}};
    bus.pt_in    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    bus.pt_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ct_valid && bus.ct_out == ct_snap && !bus.pt_ready && bus.busy) ok++;
      @(negedge clk);
    end
    check_eq("hold_stable", ok, 10);
    bus.pt_valid = 1'b0;
    bus.ct_ready = 1'b1;
    check_eq("hs_no_overlap", bus.pt_ready, 1'b0);
    @(negedge clk);
    bus.ct_ready = 1'b0;
    check_eq("post_ct_valid", bus.ct_valid, 1'b0);
    check_eq("post_pt_ready", bus.pt_ready, 1'b1);
    check_eq("post_busy", bus.busy, 1'b0);
    check_eq("post_rdy", bus.core_data_rdy, 2'b00);

    // 5: reset at LOAD_PT cycle 50
    send_pt(pt);
    repeat (128 + 50) @(negedge clk);
    check_eq("mid_rdy", bus.core_data_rdy, 2'b10);
    check_eq("mid_bit50", bus.core_data_in, pt[50]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mrst_rdy", bus.core_data_rdy, 2'b00);
    check_eq("mrst_pt_ready", bus.pt_ready, 1'b1);
    check_eq("mrst_busy", bus.busy, 1'b0);
    check_eq("mrst_ct_valid", bus.ct_valid, 1'b0);
    check_eq("mrst_data_in", bus.core_data_in, 1'b0);

    // 6: core never answers
    send_pt(pt);
    repeat (256) @(negedge clk);
    check_eq("to_run_rdy", bus.core_data_rdy, 2'b11);
`ifdef SIMON_HOST_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check_eq("to_err_early", bus.err, 1'b0);
    @(negedge clk);
    check_eq("to_err", bus.err, 1'b1);
    check_eq("to_rdy", bus.core_data_rdy, 2'b00);
    check_eq("to_busy", bus.busy, 1'b0);
    check_eq("to_pt_ready", bus.pt_ready, 1'b1);
    check_eq("to_ct_valid", bus.ct_valid, 1'b0);
    repeat (5) @(negedge clk);
    check_eq("to_err_sticky", bus.err, 1'b1);
`else
    repeat (40) @(negedge clk);
    check_eq("wait_rdy", bus.core_data_rdy, 2'b11);
    check_eq("wait_err", bus.err, 1'b0);
    check_eq("wait_busy", bus.busy, 1'b1);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("final_err", bus.err, 1'b0);
    check_eq("final_busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/simon_serial_host.md
Name: simon_serial_host

Overview:
- Host-side initiator for the bit-serial SIMON encryption core.
- Accepts a parallel plaintext block over a valid/ready handshake and serialises key and plaintext into the core's data_in / data_rdy load interface.
- Deserialises the core's serial cipher_out stream, qualified by valid, back into a parallel ciphertext word returned over a second valid/ready handshake.
- Sits between the bus/register front end and the core; owns all core sequencing.

Parameters:
- BLOCK_BITS, 128, plaintext/ciphertext width in bits (2 x 64-bit words).
- KEY_BITS, 128, key bits shifted during key load (all zeros; the core forces key to 0).
- TIMEOUT, 4095, max cycles in RUN with no core_valid before error (optional feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pt_in  input  BLOCK_BITS  plaintext block
- pt_valid  input  1  plaintext offered
- pt_ready  output  1  host can accept plaintext
- ct_out  output  BLOCK_BITS  ciphertext block
- ct_valid  output  1  ciphertext available
- ct_ready  input  1  consumer accepts ciphertext
- core_data_in  output  1  serial bit to core data_in
- core_data_rdy  output  2  core phase: 00 idle, 01 key load, 10 plaintext load, 11 run
- core_cipher_out  input  1  serial ciphertext bit from core
- core_valid  input  1  core_cipher_out holds a valid bit
- busy  output  1  high in any state other than IDLE
- err  output  1  timeout flag (constant 0 unless feature compiled in)

Behaviour:
- Reset (synchronous, active-high) applies on any clock edge, including mid-operation:
  - State returns to IDLE; all counters clear.
  - pt_ready=1, ct_valid=0, ct_out=0, core_data_in=0, core_data_rdy=00, busy=0, err=0.
- The core is not reset by this block and is reset from the same reset net.
- FSM states: IDLE, LOAD_KEY, LOAD_PT, RUN, CAPTURE, HOLD.
- IDLE:
  - pt_ready=1.
  - On pt_valid&&pt_ready, latch pt_in into the shift register and go to LOAD_KEY.
- LOAD_KEY:
  - core_data_rdy=01, core_data_in=0 for exactly KEY_BITS cycles.
  - Then go to LOAD_PT.
- LOAD_PT:
  - core_data_rdy=10 for exactly BLOCK_BITS cycles.
  - core_data_in carries plaintext LSB first (bit 0 in the first LOAD_PT cycle); the shift register shifts right.
  - Then go to RUN.
- RUN:
  - core_data_rdy=11, core_data_in=0.
  - The first cycle with core_valid=1 goes to CAPTURE, and that cycle's core_cipher_out bit is captured as bit 0.
- CAPTURE:
  - core_data_rdy stays 11.
  - Each core_valid=1 cycle shifts core_cipher_out into the MSB of the capture register (LSB-first stream) and increments a bit counter.
  - Cycles with core_valid=0 stall; no capture, counter held.
  - After BLOCK_BITS captured bits, go to HOLD.
- HOLD:
  - core_data_rdy=00, ct_valid=1, ct_out stable.
  - On ct_valid&&ct_ready, clear ct_valid and go to IDLE.
  - pt_ready rises the following cycle; no same-cycle ct/pt overlap.
- Throughput and latency:
  - pt handshake to first core_data_rdy=11 cycle is exactly 1+KEY_BITS+BLOCK_BITS cycles.
  - The ciphertext is ready one cycle after the last valid bit.
- Counters:
  - One shared counter, width clog2(max(KEY_BITS,BLOCK_BITS))+1.
  - Cleared on every state entry; never wraps within a state.
- core_valid is ignored outside RUN/CAPTURE.
- pt_valid is ignored while pt_ready=0.

Optional Feature:
- Macro: SIMON_HOST_TIMEOUT_EN.
- Defined:
  - A RUN watchdog counts cycles in RUN.
  - If TIMEOUT cycles elapse with no core_valid, set err=1 (sticky until reset), drive core_data_rdy=00 and go to IDLE; no ct_valid is produced.
  - The watchdog clears on leaving RUN.
- Undefined: err is tied 0, RUN waits indefinitely, and no watchdog logic is synthesised.

Test Plan:
1. Reset then idle:
   - Stimulus: assert reset for 2 cycles.
   - Response: pt_ready=1, busy=0, core_data_rdy=00, ct_valid=0, err=0.
2. Load sequence:
   - Stimulus: pt_in=128'h0123456789ABCDEF_FEDCBA9876543210, pt_valid for one cycle.
   - Response: 128 cycles of core_data_rdy=01 with core_data_in=0, then 128 cycles of 10 with core_data_in bits 0,0,0,0,1,0,0,0 first (LSB of ...3210), then 11.
3. Capture with stalls:
   - Stimulus: a BFM core returns 128'hA5A5...A5 LSB first, dropping core_valid on every 3rd cycle.
   - Response: ct_out=128'hA5A5...A5, ct_valid=1 one cycle after the 128th valid bit.
4. Backpressure:
   - Stimulus: hold ct_ready=0 for 10 cycles in HOLD.
   - Response: ct_valid stays 1, ct_out stable, pt_ready=0 and a new pt_valid is ignored; ct_ready=1 clears ct_valid and pt_ready=1 the next cycle.
5. Reset mid-operation:
   - Stimulus: assert reset at LOAD_PT cycle 50.
   - Response: next cycle IDLE, core_data_rdy=00, pt_ready=1, no ct_valid.
6. Timeout, feature on (TIMEOUT=16):
   - Stimulus: BFM never asserts core_valid.
   - Response: after 16 RUN cycles err=1, core_data_rdy=00, state IDLE, err held until reset.
